// File: rtl/rr_timeout_arbiter_if.sv
// Request/grant bundle between the router input ports and one output-port arbiter.
// The master side drives requests and flit info; the slave side returns the grant.
interface rr_timeout_arbiter_if #(
  parameter int NPORTS = 5,
  parameter int ID_W   = 3,
  parameter int LEN_W  = 12
);
  logic [NPORTS-1:0]       req;
  logic [NPORTS*ID_W-1:0]  flit_id;
  logic [NPORTS*LEN_W-1:0] length;
  logic [NPORTS-1:0]       grant;
  logic                    busy;
  logic [NPORTS-1:0]       timeout;

  modport master (output req, flit_id, length, input grant, busy, timeout);
  modport slave  (input req, flit_id, length, output grant, busy, timeout);
endinterface

// File: rtl/rr_timeout_arbiter.sv
// Round-robin output-port arbiter with a per-port timeout budget latched from header flits.
// Grants are held until request drop, tail flit or budget expiry, then handed on back-to-back.
module rr_timeout_arbiter #(
  parameter int NPORTS  = 5,
  parameter int ID_W    = 3,
  parameter int LEN_W   = 12,
  parameter int HEAD_ID = 1,
  parameter int TAIL_ID = 4
) (
  input  logic              clk,
  input  logic              rst,
  rr_timeout_arbiter_if.slave bus
);
  localparam int PW = $clog2(NPORTS);
  localparam logic [ID_W-1:0] HEAD_V = ID_W'(HEAD_ID);
  localparam logic [ID_W-1:0] TAIL_V = ID_W'(TAIL_ID);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_reg, state_next;
  logic [NPORTS-1:0]   grant_reg, grant_next;
  logic                busy_reg, busy_next;
  logic [NPORTS-1:0]   timeout_reg, timeout_next;
  logic [PW-1:0]       ptr_reg, ptr_next;
  logic [LEN_W-1:0]    count_reg, count_next;
  logic [LEN_W-1:0]    limit_reg [NPORTS];

  logic [ID_W-1:0]     fid_arr [NPORTS];
  logic [LEN_W-1:0]    len_arr [NPORTS];

  logic [PW-1:0]       g_idx;
  logic [PW-1:0]       base_idx;
  logic [PW-1:0]       pick_idx;
  logic                pick_valid;
  logic [LEN_W-1:0]    limit_g;
  logic                rel_drop, rel_to, rel_tail, rel_any;

  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_fields
    assign fid_arr[gi] = bus.flit_id[gi*ID_W +: ID_W];
    assign len_arr[gi] = bus.length[gi*LEN_W +: LEN_W];
  end

  // Budgets track headers on every port, whether or not that port is granted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORTS; i++) begin
      if (rst)
        limit_reg[i] <= '0;
      else if (fid_arr[i] == HEAD_V)
        limit_reg[i] <= len_arr[i];
    end
  end

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NPORTS; i++)
      if (grant_reg[i]) g_idx = PW'(i);
  end

  // Scanning from base+1 leaves the current holder last, so it only wins when alone.
  assign base_idx = (state_reg == GRANT) ? g_idx : ptr_reg;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NPORTS; k++) begin
      int j;
      j = int'(base_idx) + k;
      if (j >= NPORTS) j = j - NPORTS;
      if (!pick_valid && bus.req[j]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'(j);
      end
    end
  end

  assign limit_g  = limit_reg[g_idx];
  assign rel_drop = !bus.req[g_idx];
  assign rel_to   = (limit_g != '0) && (count_reg == limit_g - 1'b1);
  assign rel_tail = (fid_arr[g_idx] == TAIL_V);
  assign rel_any  = rel_drop || rel_to || rel_tail;

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    busy_next    = busy_reg;
    timeout_next = '0;
    ptr_next     = ptr_reg;
    count_next   = count_reg;

    if (!$onehot0(grant_reg) || (state_reg == GRANT && grant_reg == '0)) begin
      state_next = IDLE;
      grant_next = '0;
      busy_next  = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            state_next = GRANT;
            grant_next = '0;
            grant_next[pick_idx] = 1'b1;
            busy_next  = 1'b1;
            count_next = '0;
            ptr_next   = pick_idx;
          end
        end
        GRANT: begin
          if (rel_any) begin
            timeout_next[g_idx] = rel_to && !rel_tail;
            count_next = '0;
            if (pick_valid) begin
              grant_next = '0;
              grant_next[pick_idx] = 1'b1;
              ptr_next   = pick_idx;
            end else begin
              state_next = IDLE;
              grant_next = '0;
              busy_next  = 1'b0;
            end
          end else if (count_reg != '1) begin
            count_next = count_reg + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          grant_next = '0;
          busy_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      grant_reg   <= '0;
      busy_reg    <= 1'b0;
      timeout_reg <= '0;
      ptr_reg     <= PW'(NPORTS - 1);
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      busy_reg    <= busy_next;
      timeout_reg <= timeout_next;
      ptr_reg     <= ptr_next;
      count_reg   <= count_next;
    end
  end

  assign bus.grant   = grant_reg;
  assign bus.busy    = busy_reg;
  assign bus.timeout = timeout_reg;
endmodule

// File: doc/rr_timeout_arbiter.md
Name: rr_timeout_arbiter

Overview:
Parametrised successor to the fixed 5-port router output arbiter. It grants one of NPORTS input ports at a time using a rotating round-robin priority, so there is no fixed L>N>E>W>S order. Each port has its own timeout budget, latched from the header flit. A grant ends on timeout, on request drop, or on a tail flit. The block sits at each router output port and drives the crossbar select with a registered one-hot grant.

Parameters:
NPORTS, 5, number of requesting input ports (2..16)
ID_W, 3, width of each port's flit_id field
LEN_W, 12, width of each port's length (timeout budget) field
HEAD_ID, 1, flit_id value marking a header flit
TAIL_ID, 4, flit_id value marking a tail flit

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous and active-high
req  input  NPORTS  per-port request; bit i belongs to port i
flit_id  input  NPORTS*ID_W  per-port flit type; port i is bits [i*ID_W +: ID_W]
length  input  NPORTS*LEN_W  per-port timeout budget in cycles; port i is bits [i*LEN_W +: LEN_W]
grant  output  NPORTS  registered one-hot grant; all-zero when idle
busy  output  1  registered; 1 while any grant is held
timeout  output  NPORTS  one-cycle pulse on bit i when port i's grant ended by timeout

Behaviour:
- Reset values: grant=0, busy=0, timeout=0, round-robin pointer ptr=NPORTS-1, all limit registers=0, count=0, state IDLE.
- Limit registers, one per port: limit[i] <= length[i] whenever flit_id[i]==HEAD_ID. This happens regardless of grant. In the same cycle the new value is not yet visible.
- limit==0 means no timeout for that port, so its grant never ends by timeout.
- Round-robin pick: scan ports ptr+1, ptr+2, ... modulo NPORTS and take the first with req=1.
- State machine: two states, IDLE and GRANT.
- IDLE:
  - If any req is set, the pick w is computed combinationally. Next cycle: grant=onehot(w), busy=1, count=0, ptr=w, state GRANT.
  - Otherwise stay in IDLE.
  - Latency from req to grant is exactly 1 cycle.
- GRANT, holding port g. A release happens in this cycle if any of the following is true:
  - (a) req[g]==0;
  - (b) limit[g]!=0 and count==limit[g]-1, which is the timeout case;
  - (c) flit_id[g]==TAIL_ID.
- If there is no release: count <= count+1 and grant is held.
- On release, the next cycle is decided by the round-robin pick taken with ptr=g, computed over the current req:
  - The new port gets the grant back-to-back with no idle cycle, and count resets to 0.
  - If no port requests, go to IDLE with grant=0 and busy=0.
  - Port g may be re-granted only when it is the sole requester.
- Timeout pulse: timeout[g] is 1 in the cycle after a release caused by (b). Tail flit (c) takes precedence: if (b) and (c) coincide, no timeout pulse is generated.
- Grant duration: a port with limit L!=0 that keeps requesting holds grant for exactly L cycles.
- Count width is LEN_W and count must never wrap. With limit==0 the count saturates at all-ones.
- rst asserted mid-grant: the next cycle shows the reset values, and any in-flight timeout pulse is suppressed.
- grant must always be one-hot or zero. Any other value forces IDLE with grant=0 on the next cycle.

Test Plan:
- Reset then idle: rst high 2 cycles, all req=0 -> grant=0, busy=0, timeout=0 for 10 cycles.
- Single port budget: port 2 sends header with length=5, keeps req high -> grant=5'b00100 for exactly 5 cycles, timeout[2] pulses once, then port 2 is re-granted with count restarted.
- Round-robin fairness: NPORTS=5, all req high, budgets=3, no tails -> grant sequence port 0,1,2,3,4,0, each held 3 cycles, with no idle cycles between grants.
- Tail release: port 1 granted with length=100, TAIL_ID presented on cycle 4 of the grant, port 3 requesting -> grant switches to port 3 on the next cycle, and timeout stays 0.
- Zero budget and request drop: port 0 with length=0 holds grant 300 cycles while others request (no timeout); then req[0] drops -> next requester gets the grant 1 cycle later.
- Reset mid-grant: rst asserted on grant cycle 2 of a length=4 grant on port 4 -> grant=0, busy=0 and no timeout pulse on the next cycle; ptr restarts so port 0 wins first after reset.
